// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage: datapath width, instruction
// size, bubble encoding and default reset vector.
package fetch_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR_ENC    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds fetched pc/instr/valid, with hold and squash.
// Squash outranks hold and keeps the pc, replacing the instruction with a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_ENC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_hold,
    input  logic            i_squash,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_squash) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register and next-PC selection, misaligned redirect
// flag, fetched-instruction counter, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_ENC
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imemAddr,
    input  logic [XLEN-1:0] imemData,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectTarget,
    output logic [XLEN-1:0] ifIdPc,
    output logic [XLEN-1:0] ifIdPcPlus4,
    output logic [XLEN-1:0] ifIdInstr,
    output logic            ifIdValid,
    output logic            misaligned,
    output logic [XLEN-1:0] fetchCount
);

    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;
    logic [XLEN-1:0] r_fetch_count;

    logic w_hold;
    logic w_advance;

    // Redirect wins over stall, so a stall only holds when no redirect is present.
    assign w_hold    = stall & ~redirect;
    assign w_advance = ~stall & ~redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_misaligned  <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect) begin
            r_pc         <= align_pc(redirectTarget);
            r_misaligned <= |redirectTarget[1:0];
        end else begin
            r_misaligned <= 1'b0;
            if (w_advance) begin
                r_pc          <= r_pc + XLEN'(INSTR_BYTES);
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (w_hold),
        .i_squash (redirect),
        .i_pc     (r_pc),
        .i_instr  (imemData),
        .o_pc     (ifIdPc),
        .o_instr  (ifIdInstr),
        .o_valid  (ifIdValid)
    );

    assign imemAddr    = r_pc;
    assign ifIdPcPlus4 = ifIdPc + XLEN'(INSTR_BYTES);
    assign misaligned  = r_misaligned;
    assign fetchCount  = r_fetch_count;

endmodule
